// File: rtl/aes_common_pkg.sv
// Shared AES constants: the default byte width and the FIPS-197 forward and
// inverse S-box tables, indexed directly by the byte value.
package aes_common_pkg;

  localparam int NB_BYTE_DEF = 8;

  typedef logic [7:0] aes_byte_t;

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_byte_substitution_box.sv
// One combinational inverse S-box lookup.
// Ports:
//   i_byte  NB_BYTE-bit input byte
//   o_byte  NB_BYTE-bit InvSbox(i_byte)
module inv_byte_substitution_box
  import aes_common_pkg::*;
#(
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_BYTE-1:0] o_byte
);

  assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_subbytes_iterative.sv
// Iterative AES InvSubBytes: a captured state word is substituted N_LANES
// bytes per cycle through N_LANES inverse S-box instances, then held with
// o_valid until the downstream accepts it. IDLE -> BUSY -> DONE -> IDLE.
// Ports:
//   i_clock, i_reset   clock, synchronous active-high reset
//   i_state, i_valid   input state word (byte k at [k*NB_BYTE +: NB_BYTE])
//   o_ready            high only in IDLE
//   o_state, o_valid   substituted state word, valid in DONE
//   i_ready            downstream accept; releases DONE
// Build option: INV_SUBBYTES_LUT_REG_EN registers the lookup outputs before
// they are written to the result, adding one cycle of BUSY.
module inv_subbytes_iterative
  import aes_common_pkg::*;
#(
  parameter int NB_BYTE = NB_BYTE_DEF,
  parameter int N_BYTES = 16,
  parameter int N_LANES = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [N_BYTES*NB_BYTE-1:0] i_state,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [N_BYTES*NB_BYTE-1:0] o_state,
  output logic                       o_valid,
  input  logic                       i_ready
);

  if (NB_BYTE != 8) begin : g_bad_nb_byte
    $error("inv_subbytes_iterative: NB_BYTE must be 8");
  end
  if ((N_LANES < 1) || ((N_BYTES % N_LANES) != 0)) begin : g_bad_n_lanes
    $error("inv_subbytes_iterative: N_BYTES must be a multiple of N_LANES");
  end

  localparam int N_STEPS = N_BYTES / N_LANES;
  localparam int LANE_W  = N_LANES * NB_BYTE;
`ifdef INV_SUBBYTES_LUT_REG_EN
  localparam int LAST_CNT = N_STEPS;
`else
  localparam int LAST_CNT = N_STEPS - 1;
`endif
  localparam int CNT_W = (LAST_CNT < 1) ? 1 : $clog2(LAST_CNT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                 state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [N_BYTES*NB_BYTE-1:0] src_q;
  logic [N_BYTES*NB_BYTE-1:0] res_q;
  logic [LANE_W-1:0]          lane_in;
  logic [LANE_W-1:0]          lane_out;
  int                         sel_idx;

  // Lane select: the extra drain cycle of the registered build has no group
  // left to read, so the mux is parked on group 0.
  always_comb begin
    sel_idx = (int'(cnt_q) < N_STEPS) ? int'(cnt_q) : 0;
    lane_in = src_q[sel_idx*LANE_W +: LANE_W];
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    inv_byte_substitution_box #(.NB_BYTE(NB_BYTE)) u_box (
      .i_byte(lane_in[l*NB_BYTE +: NB_BYTE]),
      .o_byte(lane_out[l*NB_BYTE +: NB_BYTE])
    );
  end

`ifdef INV_SUBBYTES_LUT_REG_EN
  logic [LANE_W-1:0] lut_p1;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
`ifdef INV_SUBBYTES_LUT_REG_EN
      lut_p1  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            src_q   <= i_state;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
`ifdef INV_SUBBYTES_LUT_REG_EN
          // Stage p1: lookup of group cnt registered; group cnt-1 retired.
          if (int'(cnt_q) < N_STEPS) lut_p1 <= lane_out;
          if (cnt_q != '0) res_q[(int'(cnt_q)-1)*LANE_W +: LANE_W] <= lut_p1;
`else
          res_q[int'(cnt_q)*LANE_W +: LANE_W] <= lane_out;
`endif
          if (cnt_q == CNT_W'(LAST_CNT)) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (i_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_state = res_q;

endmodule

// File: tb/tb_inv_subbytes_iterative.sv
module tb_inv_subbytes_iterative;

`ifdef INV_SUBBYTES_LUT_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LANES [3] = '{1, 4, 16};

  logic         clk;
  logic         rst;
  logic [127:0] st_in  [3];
  logic [127:0] st_out [3];
  logic         vin    [3];
  logic         rdy_o  [3];
  logic         vo     [3];
  logic         rdy_i  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_subbytes_iterative #(.NB_BYTE(8), .N_BYTES(16), .N_LANES(LANES[g])) u_dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_state(st_in[g]),
      .i_valid(vin[g]),
      .o_ready(rdy_o[g]),
      .o_state(st_out[g]),
      .o_valid(vo[g]),
      .i_ready(rdy_i[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];

  // Independent reference: S-box derived from GF(2^8) inversion + affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = inv_tab[s[k*8 +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Entered #1 after the accepting edge; waits for o_valid, compares against
  // the scoreboard head, then lets the block return to IDLE (i_ready=1).
  task automatic wait_result(input int d, input string tag);
    int lat = 0;
    logic [127:0] e;
    while (!vo[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(16 / LANES[d] + EXTRA));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    chk({tag, "_data"}, st_out[d], e);
    @(posedge clk); #1;
    chk({tag, "_vld_1cyc"}, 128'(vo[d]), 128'd0);
  endtask

  task automatic run_txn(input int d, input logic [127:0] s, input string tag);
    exp_q.push_back(model(s));
    st_in[d] = s;
    vin[d] = 1'b1;
    @(posedge clk); #1;
    vin[d] = 1'b0;
    wait_result(d, tag);
  endtask

  logic [127:0] s, held;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      st_in[d] = '0; vin[d] = 1'b0; rdy_i[d] = 1'b1;
    end
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 8'h00;
      logic [7:0] f;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      f = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_tab[x] = f;
      inv_tab[f] = 8'(x);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready%0d", d), 128'(rdy_o[d]), 128'd1);
      chk($sformatf("rst_valid%0d", d), 128'(vo[d]), 128'd0);
      chk($sformatf("rst_state%0d", d), st_out[d], 128'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // All 0x63 -> all 0x00
    run_txn(1, {16{8'h63}}, "all63");
    chk("all63_zero", 128'd0, model({16{8'h63}}));

    // byte k = Sbox(k) -> byte k = k
    for (int k = 0; k < 16; k++) s[k*8 +: 8] = fwd_tab[k];
    chk("fwd_byte0", 128'(s[7:0]), 128'h63);
    chk("fwd_byte1", 128'(s[15:8]), 128'h7c);
    run_txn(1, s, "fwdk");
    chk("fwdk_identity", st_out[1], 128'h0f0e0d0c0b0a09080706050403020100);

    // Single known bytes
    s = '0; s[7:0] = 8'h00; s[15:8] = 8'h16; s[23:16] = 8'hed;
    run_txn(1, s, "single");
    chk("single_00", 128'(st_out[1][7:0]), 128'h52);
    chk("single_16", 128'(st_out[1][15:8]), 128'hff);
    chk("single_ed", 128'(st_out[1][23:16]), 128'h53);

    // Backpressure in DONE; new input ignored while held
    rdy_i[1] = 1'b0;
    s = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(s));
    st_in[1] = s; vin[1] = 1'b1;
    @(posedge clk); #1;
    vin[1] = 1'b0;
    begin
      int lat = 0;
      while (!vo[1] && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("hold_lat", 128'(lat), 128'(4 + EXTRA));
    end
    held = st_out[1];
    chk("hold_data", held, exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        st_in[1] = ~s; vin[1] = 1'b1;
      end
      @(posedge clk); #1;
      vin[1] = 1'b0;
      chk($sformatf("hold_vld%0d", i), 128'(vo[1]), 128'd1);
      chk($sformatf("hold_state%0d", i), st_out[1], held);
      chk($sformatf("hold_rdy%0d", i), 128'(rdy_o[1]), 128'd0);
    end
    // i_valid offered on the DONE->IDLE edge is not taken; next edge is
    s = {$urandom, $urandom, $urandom, $urandom};
    st_in[1] = s; vin[1] = 1'b1; rdy_i[1] = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 128'(rdy_o[1]), 128'd1);
    chk("release_valid", 128'(vo[1]), 128'd0);
    chk("release_state", st_out[1], held);
    exp_q.push_back(model(s));
    @(posedge clk); #1;
    vin[1] = 1'b0;
    chk("next_accept", 128'(rdy_o[1]), 128'd0);
    wait_result(1, "next");

    // Reset during step 2, with i_valid also high
    s = {$urandom, $urandom, $urandom, $urandom};
    st_in[1] = s; vin[1] = 1'b1;
    @(posedge clk); #1;
    vin[1] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; vin[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; vin[1] = 1'b0;
    chk("abort_valid", 128'(vo[1]), 128'd0);
    chk("abort_state", st_out[1], 128'd0);
    chk("abort_ready", 128'(rdy_o[1]), 128'd1);
    run_txn(1, {$urandom, $urandom, $urandom, $urandom}, "after_abort");

    // Random sweep over 1, 4 and 16 lanes
    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 1000; n++)
        run_txn(d, {$urandom, $urandom, $urandom, $urandom}, $sformatf("rnd_l%0d", LANES[d]));

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_subbytes_iterative.md
INV_SUBBYTES_ITERATIVE -- requirements
Module: inv_subbytes_iterative

Interface
REQ-001 SHALL have parameter NB_BYTE, default 8, bits per byte; any value other than 8 is a bad configuration and SHALL fail elaboration.
REQ-002 SHALL have parameter N_BYTES, default 16, bytes per state word.
REQ-003 SHALL have parameter N_LANES, default 4, inverse S-box lookups per cycle; N_BYTES mod N_LANES != 0 SHALL fail elaboration.
REQ-004 i_clock  input  1  single clock; all logic on rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_state  input  N_BYTES*NB_BYTE  ciphertext-side state; byte k at [k*NB_BYTE +: NB_BYTE].
REQ-007 i_valid  input  1  i_state valid.
REQ-008 o_ready  output  1  block can accept i_state.
REQ-009 o_state  output  N_BYTES*NB_BYTE  InvSubBytes result; same byte ordering as i_state.
REQ-010 o_valid  output  1  o_state valid.
REQ-011 i_ready  input  1  downstream accepts o_state.

Function
REQ-012 Define N_STEPS = N_BYTES/N_LANES; the block SHALL have states IDLE, BUSY, DONE.
REQ-013 IDLE: o_ready=1, o_valid=0; on i_valid=1, capture i_state into the source register, clear the step counter, go to BUSY.
REQ-014 BUSY: o_ready=0, o_valid=0; at each edge, step s (0..N_STEPS-1) writes InvSbox of source bytes [s*N_LANES .. s*N_LANES+N_LANES-1] into the matching result bytes; s increments by 1.
REQ-015 After the step with s=N_STEPS-1, the counter SHALL wrap to 0 and the FSM SHALL enter DONE.
REQ-016 DONE: o_valid=1, o_ready=0; o_state SHALL equal the full result and stay stable until i_ready=1; on i_ready=1, go to IDLE.
REQ-017 Latency: o_valid SHALL assert N_STEPS cycles after the accepting edge (macro off).
REQ-018 i_valid SHALL be ignored whenever o_ready=0; no input is captured or queued in BUSY or DONE.
REQ-019 A new input SHALL NOT be accepted in the DONE-to-IDLE cycle; the earliest next acceptance is the first cycle in IDLE, so maximum throughput is one state per N_STEPS+2 cycles.
REQ-020 With N_LANES=N_BYTES, BUSY SHALL last exactly one cycle.
REQ-021 InvSbox SHALL be the FIPS-197 inverse S-box; no other transform is applied.

Reset
REQ-022 While i_reset=1: FSM=IDLE, step counter=0, source and result registers=0, o_state=0, o_valid=0, o_ready=1 after the reset edge.
REQ-023 Reset asserted in BUSY or DONE SHALL abort the operation with no output; the partial result is discarded.
REQ-024 Reset SHALL take priority over i_valid and i_ready in the same cycle.

Configuration
REQ-025 Macro INV_SUBBYTES_LUT_REG_EN SHALL be provided; when defined, N_LANES lookup outputs are registered before being written to the result, and BUSY lasts N_STEPS+1 cycles.
REQ-026 With INV_SUBBYTES_LUT_REG_EN defined, latency SHALL be N_STEPS+1 cycles; the lookup register SHALL reset to 0.
REQ-027 Without the macro, lookups are combinational into the result register, with the latency of REQ-017.
REQ-028 The handshake, ordering and reset behaviour SHALL be identical with and without the macro.

Structure
REQ-029 Shared package aes_common_pkg SHALL hold the 256-entry INV_SBOX constant table and the NB_BYTE default; the forward S-box table is kept in the same package.
REQ-030 Sub-module inv_byte_substitution_box SHALL implement one combinational NB_BYTE lookup and be instantiated N_LANES times in a generate loop.
REQ-031 Lane-select muxing, the step counter and the FSM SHALL reside in inv_subbytes_iterative.

Verification
REQ-032 All bytes 0x63, i_ready=1, N_LANES=4 -> o_state all 0x00; o_valid asserts 4 cycles after acceptance, for 1 cycle.
REQ-033 Byte k = FwdSbox(k) for k=0..15 (0x63,0x7C,0x77,...) -> byte k = k; also check single bytes 0x00->0x52, 0x16->0xFF, 0xED->0x53.
REQ-034 i_ready held at 0 for 10 cycles in DONE, i_valid pulsed with a new state -> o_state unchanged, o_valid=1 throughout, new state not captured; after i_ready=1, o_ready=1 on the next cycle.
REQ-035 i_reset pulsed during step 2 -> o_valid=0, o_state=0, o_ready=1 on the next cycle; a subsequent transaction completes correctly.
REQ-036 Sweep N_LANES in {1,4,16}, each with and without INV_SUBBYTES_LUT_REG_EN, with 1000 random states -> results match the inverse-table model, with latency 16/4/1 cycles (+1 when the macro is defined).
